// File: rtl/stage1_msp_incrementer.sv
// Stack-pointer (MSP) update unit: a WIDTH-bit register stepped by +1/-1,
// with write enable and direction delayed through a CTRL_STAGES-deep pipeline.
module stage1_msp_incrementer #(
  parameter int WIDTH       = 16,
  parameter int CTRL_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             RegWrite,
  input  logic             Op,
  output logic [WIDTH-1:0] RegOut
);

  // Stage 0 of each vector is we_s1/op_s1; the last stage drives the register.
  logic [CTRL_STAGES-1:0] we_pipe;
  logic [CTRL_STAGES-1:0] op_pipe;
  logic [WIDTH-1:0]       msp_q;

  logic             we_last;
  logic             op_last;
  logic [WIDTH-1:0] msp_next;

  assign we_last = we_pipe[CTRL_STAGES-1];
  assign op_last = op_pipe[CTRL_STAGES-1];

  // Modulo-2^WIDTH step; wrap in both directions falls out of the fixed width.
  always_comb begin
    msp_next = msp_q;
    if (we_last) begin
      msp_next = op_last ? (msp_q - 1'b1) : (msp_q + 1'b1);
    end
  end

  // NOTE: non-blocking assignments let every stage read its predecessor's
  // pre-edge value, so the pipeline shifts by exactly one stage per clock.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      we_pipe <= '0;
      op_pipe <= '0;
      msp_q   <= '0;
    end else begin
      we_pipe[0] <= RegWrite;
      op_pipe[0] <= Op;
      for (int i = 1; i < CTRL_STAGES; i++) begin
        we_pipe[i] <= we_pipe[i-1];
        op_pipe[i] <= op_pipe[i-1];
      end
      msp_q <= msp_next;
    end
  end

  assign RegOut = msp_q;

endmodule

// File: tb/tb_stage1_msp_incrementer.sv
// Self-checking bench for stage1_msp_incrementer: directed scenarios plus
// randomized traffic compared against a queue-based latency model.
module tb_stage1_msp_incrementer;

  localparam int W       = 16;
  localparam int LATENCY = 2;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         RegWrite;
  logic         Op;
  logic [W-1:0] RegOut;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: every sampled request waits LATENCY edges, then adjusts a counter.
  logic [W-1:0] exp_val;
  logic [1:0]   pending[$];

  stage1_msp_incrementer #(.WIDTH(W), .CTRL_STAGES(LATENCY)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .RegWrite (RegWrite),
    .Op       (Op),
    .RegOut   (RegOut)
  );

  always #5 CLK = ~CLK;

  task automatic model_reset();
    pending.delete();
    exp_val = '0;
  endtask

  task automatic model_edge(input logic we, input logic op);
    logic [1:0] req;
    if (RST_N !== 1'b1) return;
    pending.push_back({we, op});
    if (pending.size() > LATENCY) begin
      req = pending.pop_front();
      if (req[1]) exp_val = req[0] ? exp_val - 1 : exp_val + 1;
    end
  endtask

  // Drive inputs in the low phase, let one rising edge happen, return at the next falling edge.
  task automatic tick(input logic we, input logic op);
    RegWrite = we;
    Op       = op;
    @(posedge CLK);
    model_edge(we, op);
    @(negedge CLK);
  endtask

  // Called at a falling edge; asserts reset asynchronously in the middle of the low phase.
  task automatic assert_reset();
    #2;
    RST_N = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    n_total++;
    if (RegOut !== 16'h0000) $display("FAIL reset_initial: got %h want 0000", RegOut);
    else n_pass++;
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0);
    n_total++;
    if (RegOut !== 16'd4) $display("FAIL reset_preload: got %h want 0004", RegOut);
    else n_pass++;
    assert_reset();
    n_total++;
    if (RegOut !== 16'h0000) $display("FAIL reset_async: got %h want 0000", RegOut);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0);
      n_total++;
      if (RegOut !== 16'h0000) $display("FAIL reset_held[%0d]: got %h want 0000", i, RegOut);
      else n_pass++;
    end
  endtask

  task automatic test_count_up();
    logic [W-1:0] first[4];
    first = '{16'd0, 16'd0, 16'd1, 16'd2};
    RST_N = 1'b1;
    for (int n = 1; n <= 35; n++) begin
      tick(1'b1, 1'b0);
      n_total++;
      if (RegOut !== exp_val) $display("FAIL count_up_model edge %0d: got %h want %h", n, RegOut, exp_val);
      else n_pass++;
      if (n <= 4) begin
        n_total++;
        if (RegOut !== first[n-1]) $display("FAIL count_up_start edge %0d: got %h want %h", n, RegOut, first[n-1]);
        else n_pass++;
      end
    end
    n_total++;
    if (RegOut !== 16'd33) $display("FAIL count_up_edge35: got %h want 0021", RegOut);
    else n_pass++;
  endtask

  task automatic test_count_down();
    logic [W-1:0] turn[4];
    turn = '{16'd34, 16'd35, 16'd34, 16'd33};
    for (int n = 36; n <= 67; n++) begin
      tick(1'b1, 1'b1);
      n_total++;
      if (RegOut !== exp_val) $display("FAIL count_down_model edge %0d: got %h want %h", n, RegOut, exp_val);
      else n_pass++;
      if (n <= 39) begin
        n_total++;
        if (RegOut !== turn[n-36]) $display("FAIL count_down_turn edge %0d: got %h want %h", n, RegOut, turn[n-36]);
        else n_pass++;
      end
    end
    n_total++;
    if (RegOut !== 16'd5) $display("FAIL count_down_edge67: got %h want 0005", RegOut);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [W-1:0] seq[4];
    logic         ops[4];
    seq = '{16'h0000, 16'h0000, 16'hFFFF, 16'h0000};
    ops = '{1'b1, 1'b0, 1'b0, 1'b0};
    assert_reset();
    release_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, ops[i]);
      n_total++;
      if (RegOut !== seq[i]) $display("FAIL wrap edge %0d: got %h want %h", i + 1, RegOut, seq[i]);
      else n_pass++;
    end
    n_total++;
    if (RegOut !== exp_val) $display("FAIL wrap_model: got %h want %h", RegOut, exp_val);
    else n_pass++;
  endtask

  task automatic test_hold();
    logic [W-1:0] seq[4];
    logic         wes[4];
    seq = '{16'd11, 16'd12, 16'd12, 16'd13};
    wes = '{1'b0, 1'b1, 1'b1, 1'b1};
    assert_reset();
    release_reset();
    for (int n = 1; n <= 12; n++) tick(1'b1, 1'b0);
    n_total++;
    if (RegOut !== 16'd10) $display("FAIL hold_preload: got %h want 000a", RegOut);
    else n_pass++;
    // The RegWrite=0 sample comes with Op=1 to show Op is ignored without a write.
    for (int i = 0; i < 4; i++) begin
      tick(wes[i], wes[i] ? 1'b0 : 1'b1);
      n_total++;
      if (RegOut !== seq[i]) $display("FAIL hold step %0d: got %h want %h", i, RegOut, seq[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] seq[3];
    seq = '{16'd0, 16'd0, 16'd1};
    assert_reset();
    release_reset();
    for (int n = 1; n <= 22; n++) tick(1'b1, 1'b0);
    n_total++;
    if (RegOut !== 16'd20) $display("FAIL midrun_preload: got %h want 0014", RegOut);
    else n_pass++;
    assert_reset();
    n_total++;
    if (RegOut !== 16'h0000) $display("FAIL midrun_async: got %h want 0000", RegOut);
    else n_pass++;
    release_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0);
      n_total++;
      if (RegOut !== seq[i]) $display("FAIL midrun_restart edge %0d: got %h want %h", i + 1, RegOut, seq[i]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, i[0]);
      n_total++;
      if (RegOut !== exp_val) $display("FAIL back_to_back step %0d: got %h want %h", i, RegOut, exp_val);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        assert_reset();
        n_total++;
        if (RegOut !== 16'h0000) $display("FAIL random_reset step %0d: got %h want 0000", i, RegOut);
        else n_pass++;
        release_reset();
      end
      tick(1'($urandom_range(0, 3) != 0), 1'($urandom));
      n_total++;
      if (RegOut !== exp_val) $display("FAIL random step %0d: got %h want %h", i, RegOut, exp_val);
      else n_pass++;
    end
  endtask

  initial begin
    RST_N    = 1'b0;
    RegWrite = 1'b0;
    Op       = 1'b0;
    model_reset();
    test_reset();
    test_count_up();
    test_count_down();
    test_wrap();
    test_hold();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
